// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmit device: register addresses,
// STATUS bit positions and the transmit FSM state encoding.
package uart_tx_dev_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_DONE  = 3;
  localparam int STAT_OVF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter.
// Ports: clk, rst_n (async active-low), push/din (enqueue), pop/dout
// (dequeue, dout shows the head), full, empty, count (occupancy).
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointer width equals log2(DEPTH), so increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// UART transmitter device on the bridge bus.
// Ports: clk, reset (async active-low), addr/Uart_Wr/DataIn (bus write),
// DataOut (combinational read), tx (serial line, idles high),
// Uart_IRQ (done AND IE).
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a byte in the FIFO
// ST_START | start bit (low)
// ST_DATA  | 8 data bits, LSB first
// ST_STOP  | stop bit (high); pops the next byte directly if one waits
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        Uart_Wr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        tx,
  output logic        Uart_IRQ
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          done_set;
  logic          pop;
  logic          push;
  logic          ctrl_wr;
  logic          stat_wr;
  logic          ie;
  logic          done;
  logic          ovf;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_data;

  assign push    = Uart_Wr && (addr == ADDR_DATA);
  assign ctrl_wr = Uart_Wr && (addr == ADDR_CTRL);
  assign stat_wr = Uart_Wr && (addr == ADDR_STATUS);
  assign unused_data = ^DataIn[31:8];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (DataIn[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

  // tx is registered from the current state, so the line trails the state
  // by one cycle; frame timing is unaffected since every bit shifts equally.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    pop       = 1'b0;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          baud_nxt  = BAUD_RELOAD;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_nxt = 1'b0;
        if (baud_cnt == '0) begin
          baud_nxt  = BAUD_RELOAD;
          bit_nxt   = 3'd0;
          state_nxt = ST_DATA;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        tx_nxt = shift[0];
        if (baud_cnt == '0) begin
          baud_nxt  = BAUD_RELOAD;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_nxt = ST_STOP;
          else                 bit_nxt   = bit_cnt + 1'b1;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      ST_STOP: begin
        tx_nxt = 1'b1;
        if (baud_cnt == '0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            baud_nxt  = BAUD_RELOAD;
            state_nxt = ST_START;
          end else begin
            done_set  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as a software clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie   <= 1'b0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= DataIn[0];
      if (done_set)                 done <= 1'b1;
      else if (stat_wr && DataIn[3]) done <= 1'b0;
      if (push && fifo_full && !pop) ovf <= 1'b1;
      else if (stat_wr && DataIn[4]) ovf <= 1'b0;
    end
  end

  assign Uart_IRQ = done & ie;

  always_comb begin
    DataOut = '0;
    case (addr)
      ADDR_CTRL:   DataOut[0] = ie;
      ADDR_STATUS: begin
        DataOut[STAT_BUSY]  = (state != ST_IDLE);
        DataOut[STAT_FULL]  = fifo_full;
        DataOut[STAT_EMPTY] = fifo_empty;
        DataOut[STAT_DONE]  = done;
        DataOut[STAT_OVF]   = ovf;
      end
      ADDR_COUNT:  DataOut = 32'(fifo_count);
      default:     DataOut = '0;
    endcase
  end

endmodule
